p16_deuwuifier: RTL and testbench
=================================

# p16_deuwuifier

UART-to-UART text filter that undoes uwuification. It collapses the expansions `owo`→`o`, `OWO`→`O`, `uwu`→`u` and `UWU`→`U` at match points and passes every other byte through unchanged. The block sits at the chip top in place of the uwuifier. It reuses `p16_uart_rx`, `p16_uart_tx` and `p16_uart_fifo`, with the FIFO configured as WIDTH=8, DEPTH=8, ALMOST_FULL=4.

## Interface
- `CLK_FREQ`, default 250000: clock frequency in Hz, passed to the UART instances.
- `BAUD`, default 9600: line rate, passed to the UART instances.
- `TIMEOUT_CYC`, default 12*CLK_FREQ/BAUD: idle cycles before a held partial match is flushed. Used only with `DEUWU_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `rx`  in  1  UART serial input.
- `tx`  out  1  UART serial output; idles high, including during reset.
- `dbg`  out  24  debug bus:
  - [3:0] FSM state.
  - [7:4] zero.
  - [15:8] last received byte.
  - [23:16] held byte `c1`.

## Operation
- Received byte `b` arrives when `urx_valid`=1. FIFO writes happen combinationally in the same cycle as the state logic.
- Registers:
  - `c1`: held first character.
  - `pend`: byte to be replayed.
  - `replay_vld`: a replay is owed.
- Letter = `A`..`Z` or `a`..`z`.
- Expected second character: `wch` = `w` if `c1` is lowercase, `W` if `c1` is uppercase.
- State encoding: READY=0, WAIT_SPACE=1, M1=2, M2=3, FLUSH_W=4, REPLAY=5.

State behaviour:
- **READY** (on `b`):
  - If `b`∈{o,O,u,U} and FIFO not almost_full: `c1`←`b`, no write, go to M1.
  - Otherwise: write `b`, stay in READY.
- **M1** (on `b`):
  - If `b`==`wch`: go to M2, no write.
  - Otherwise: write `c1`, `pend`←`b`, `replay_vld`←1, go to REPLAY.
- **M2** (on `b`):
  - If `b`==`c1`: write `c1`, go to WAIT_SPACE.
  - Otherwise: write `c1`, `pend`←`b`, `replay_vld`←1, go to FLUSH_W.
- **FLUSH_W**: write `wch` unconditionally.
  - If `replay_vld`=1: go to REPLAY.
  - Otherwise: go to READY.
- **REPLAY**: apply the READY rules to `pend` as if it had just been received, then clear `replay_vld`.
- **WAIT_SPACE** (on `b`): write `b`.
  - If `b` is not a letter: go to READY.
  - Otherwise: stay in WAIT_SPACE.

Other rules:
- A `urx_valid` arriving in FLUSH_W or REPLAY is ignored. This cannot happen for CLK_FREQ/BAUD ≥ 16, because bytes are ≥160 cycles apart.
- FIFO read side:
  - `rd_en` = `utx_ready` && !empty && !`utx_valid`.
  - `utx_data`/`utx_valid` come from the FIFO.
- FIFO full: writes are dropped.
- Almost_full in READY disables capture, so the byte passes through verbatim.

## Timing
- Reset: state=READY, `c1`=`pend`=0, `replay_vld`=0, `dbg`=0, FIFO empty, `tx`=1.
- Pass-through byte: FIFO write in the cycle `urx_valid` is asserted.
- A mismatch emits at most 3 bytes over consecutive cycles, in this order: `c1`, `wch` (M2 only), `pend`.
- A completed match writes exactly one byte (`c1`), in the cycle the third character arrives.
- Reset mid-match discards `c1`/`pend` without emitting them.

## Configuration
- `DEUWU_TIMEOUT_EN` defined:
  - A cycle counter clears on every `urx_valid` and counts while the state is M1 or M2.
  - On reaching `TIMEOUT_CYC`:
    - From M1: write `c1`, go to READY.
    - From M2: write `c1`, go to FLUSH_W with `replay_vld`=0.
- `DEUWU_TIMEOUT_EN` undefined: no counter. A held match waits indefinitely for the next byte.

## Test plan
- "owo " → tx "o ". The FSM passes READY→M1→M2→WAIT_SPACE→READY.
- "UWU!" → "U!".
- "hellowo world\n" → "hello world\n". The `o` inside "hello" starts a match that completes.
- "owO " → "owO ". In M2, the case mismatch flushes `o`,`w`, then the replayed `O` is captured and later flushed by the space.
- "ow" then idle for 3 byte times:
  - With `DEUWU_TIMEOUT_EN`: "ow" appears on tx.
  - Without it: nothing is sent until the next byte; a following "x" yields "owx".
- `rst` asserted after "uw", then "a" sent → tx "a" only; `dbg[3:0]`=0 after reset.

Source files
------------

// File: rtl/p16_deuwuifier.sv
// p16_deuwuifier: UART-to-UART filter that collapses owo/OWO/uwu/UWU back to
// their single vowel and passes every other byte through unchanged.
// Build option: define DEUWU_TIMEOUT_EN to flush a held partial match after
// TIMEOUT_CYC idle cycles; without it a partial match waits for the next byte.
// Handshake: a byte moves on a valid/ready pair only in a cycle where both are
// high; valid, once raised, holds its data stable until that cycle.

module p16_uart_rx #(
  parameter int CPB = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  logic        s1_q, s2_q, busy_q, busy_d, valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;

  // Two-flop synchroniser plus frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1; s2_q <= 1'b1; busy_q <= 1'b0; valid_q <= 1'b0;
      cnt_q <= '0; bit_q <= '0; sh_q <= '0;
    end else begin
      s1_q <= rx; s2_q <= s1_q; busy_q <= busy_d; valid_q <= valid_d;
      cnt_q <= cnt_d; bit_q <= bit_d; sh_q <= sh_d;
    end
  end

  // Sample each bit mid-cell; slot 0 re-checks the start bit, slot 9 is stop.
  always_comb begin
    busy_d = busy_q; cnt_d = cnt_q; bit_d = bit_q; sh_d = sh_q; valid_d = 1'b0;
    if (!busy_q) begin
      if (!s2_q) begin
        busy_d = 1'b1; cnt_d = 16'(CPB / 2 - 1); bit_d = 4'd0;
      end
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = 16'(CPB - 1);
      bit_d = bit_q + 4'd1;
      if (bit_q == 4'd0) begin
        if (s2_q) busy_d = 1'b0;
      end else if (bit_q <= 4'd8) begin
        sh_d = {s2_q, sh_q[7:1]};
      end else begin
        busy_d  = 1'b0;
        valid_d = s2_q;
      end
    end
  end

  assign data  = sh_q;
  assign valid = valid_q;
endmodule

module p16_uart_tx #(
  parameter int CPB = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  sh_q, sh_d;

  // Frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0; cnt_q <= '0; bit_q <= '0; sh_q <= '1;
    end else begin
      busy_q <= busy_d; cnt_q <= cnt_d; bit_q <= bit_d; sh_q <= sh_d;
    end
  end

  // Load {stop, data, start} on accept, then shift one bit per cell.
  always_comb begin
    busy_d = busy_q; cnt_d = cnt_q; bit_d = bit_q; sh_d = sh_q;
    if (!busy_q) begin
      if (valid) begin
        busy_d = 1'b1; sh_d = {1'b1, data, 1'b0};
        cnt_d = 16'(CPB - 1); bit_d = 4'd0;
      end
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = 16'(CPB - 1);
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
      end else begin
        sh_d  = {1'b1, sh_q[9:1]};
        bit_d = bit_q + 4'd1;
      end
    end
  end

  assign ready = !busy_q;
  assign tx    = busy_q ? sh_q[0] : 1'b1;
endmodule

module p16_uart_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int ALMOST_FULL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // Pointer and occupancy update; writes when full are dropped.
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= (AW+1)'(ALMOST_FULL));
endmodule

module p16_deuwuifier #(
  parameter int CLK_FREQ    = 250000,
  parameter int BAUD        = 9600,
  parameter int TIMEOUT_CYC = 12 * CLK_FREQ / BAUD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic [23:0] dbg
);
  localparam int CPB = CLK_FREQ / BAUD;

  typedef enum logic [3:0] {
    READY = 4'd0, WAIT_SPACE = 4'd1, M1 = 4'd2, M2 = 4'd3, FLUSH_W = 4'd4, REPLAY = 4'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] c1_q, c1_d, pend_q, pend_d, last_q, last_d, utx_data_q, utx_data_d;
  logic       replay_vld_q, replay_vld_d, utx_valid_q, utx_valid_d;
  logic [7:0] urx_data, wr_data, rd_data, wch, cap_src;
  logic       urx_valid, wr_en, rd_en, full, empty, almost_full, utx_ready;
  logic       cap_go, tmo_hit;

  function automatic logic is_cap(input logic [7:0] c);
    return (c == "o") || (c == "O") || (c == "u") || (c == "U");
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= "a") && (c <= "z")) || ((c >= "A") && (c <= "Z"));
  endfunction

  p16_uart_rx #(.CPB(CPB)) u_rx (.clk(clk), .rst(rst), .rx(rx), .data(urx_data), .valid(urx_valid));

  p16_uart_fifo #(.WIDTH(8), .DEPTH(8), .ALMOST_FULL(4)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr_en && !full), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full));

  p16_uart_tx #(.CPB(CPB)) u_tx (
    .clk(clk), .rst(rst), .data(utx_data_q), .valid(utx_valid_q), .ready(utx_ready), .tx(tx));

  assign wch = ((c1_q >= "a") && (c1_q <= "z")) ? "w" : "W";

`ifdef DEUWU_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Idle counter: runs only while a match is held, restarts on every byte.
  always_comb begin
    tmo_d   = 32'd0;
    tmo_hit = 1'b0;
    if (!urx_valid && ((state_q == M1) || (state_q == M2))) begin
      tmo_d   = tmo_q + 32'd1;
      tmo_hit = (tmo_q == 32'(TIMEOUT_CYC - 1));
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= 32'd0;
    else     tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYC == 0);
`endif

  // Match FSM; READY and REPLAY share the capture-or-pass decision below.
  always_comb begin
    state_d = state_q; c1_d = c1_q; pend_d = pend_q; replay_vld_d = replay_vld_q;
    wr_en = 1'b0; wr_data = urx_data; cap_go = 1'b0; cap_src = urx_data;
    last_d = urx_valid ? urx_data : last_q;
    unique case (state_q)
      READY: cap_go = urx_valid;
      M1: begin
        if (urx_valid) begin
          if (urx_data == wch) begin
            state_d = M2;
          end else begin
            wr_en = 1'b1; wr_data = c1_q; pend_d = urx_data; replay_vld_d = 1'b1; state_d = REPLAY;
          end
        end else if (tmo_hit) begin
          wr_en = 1'b1; wr_data = c1_q; state_d = READY;
        end
      end
      M2: begin
        if (urx_valid) begin
          wr_en = 1'b1; wr_data = c1_q;
          if (urx_data == c1_q) begin
            state_d = WAIT_SPACE;
          end else begin
            pend_d = urx_data; replay_vld_d = 1'b1; state_d = FLUSH_W;
          end
        end else if (tmo_hit) begin
          wr_en = 1'b1; wr_data = c1_q; replay_vld_d = 1'b0; state_d = FLUSH_W;
        end
      end
      FLUSH_W: begin
        wr_en = 1'b1; wr_data = wch;
        state_d = replay_vld_q ? REPLAY : READY;
      end
      REPLAY: begin
        cap_go = 1'b1; cap_src = pend_q; replay_vld_d = 1'b0;
      end
      WAIT_SPACE: begin
        if (urx_valid) begin
          wr_en = 1'b1;
          if (!is_letter(urx_data)) state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
    if (cap_go) begin
      if (is_cap(cap_src) && !almost_full) begin
        c1_d = cap_src; state_d = M1;
      end else begin
        wr_en = 1'b1; wr_data = cap_src; state_d = READY;
      end
    end
  end

  // FIFO drain into the transmitter through a one-entry output register.
  always_comb begin
    rd_en       = utx_ready && !empty && !utx_valid_q;
    utx_valid_d = utx_valid_q;
    utx_data_d  = utx_data_q;
    if (utx_valid_q && utx_ready) utx_valid_d = 1'b0;
    if (rd_en) begin
      utx_valid_d = 1'b1; utx_data_d = rd_data;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= READY; c1_q <= 8'd0; pend_q <= 8'd0; last_q <= 8'd0;
      replay_vld_q <= 1'b0; utx_valid_q <= 1'b0; utx_data_q <= 8'd0;
    end else begin
      state_q <= state_d; c1_q <= c1_d; pend_q <= pend_d; last_q <= last_d;
      replay_vld_q <= replay_vld_d; utx_valid_q <= utx_valid_d; utx_data_q <= utx_data_d;
    end
  end

  assign dbg = {c1_q, last_q, 4'b0000, state_q};
endmodule

// File: tb/tb_p16_deuwuifier.sv
// Testbench for p16_deuwuifier: serial driver on rx, serial monitor on tx
// checked against a text-level de-uwuify model through an expected queue.
module tb_p16_deuwuifier;
  localparam int CLK_FREQ = 160000;
  localparam int BAUD     = 10000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [23:0] dbg;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];

  p16_deuwuifier #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .dbg(dbg));

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic bit is_letter(input logic [7:0] c);
    return ((c >= "a") && (c <= "z")) || ((c >= "A") && (c <= "Z"));
  endfunction

  // Text-level reference: a vowel-w-vowel triple with matching case collapses
  // to the vowel and the rest of that word is copied verbatim; otherwise the
  // byte is copied and scanning resumes at the next byte.
  function automatic void model();
    int         i = 0;
    int         n = stim_q.size();
    bit         tail = 0;
    logic [7:0] c, w;
    while (i < n) begin
      c = stim_q[i];
      if (tail) begin
        exp_q.push_back(c);
        tail = is_letter(c);
        i++;
      end else if (c == "o" || c == "O" || c == "u" || c == "U") begin
        w = (c == "o" || c == "u") ? 8'h77 : 8'h57;
        if (i + 1 >= n) break;
        if (stim_q[i+1] != w) begin
          exp_q.push_back(c); i++;
        end else if (i + 2 >= n) begin
          break;
        end else if (stim_q[i+2] == c) begin
          exp_q.push_back(c); tail = 1; i += 3;
        end else begin
          exp_q.push_back(c); i++;
        end
      end else begin
        exp_q.push_back(c); i++;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_stim();
    model();
    foreach (stim_q[k]) send_byte(stim_q[k]);
  endtask

  task automatic run_str(input string s);
    stim_q.delete();
    for (int k = 0; k < s.len(); k++) stim_q.push_back(s[k]);
    send_stim();
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (4 * CPB) @(negedge clk);
  endtask

  // Monitor: decode tx frames and pop the expected queue for each byte.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
          errors++;
          $display("FAIL tx_stop: got %b expected 1 (byte %02h)", tx, b);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got %02h expected no byte", b);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (b !== e) begin
            errors++;
            $display("FAIL tx_byte: got %02h expected %02h", b, e);
          end
        end
      end
    end
  end

  // Main sequence.
  initial begin : main
    string alpha;
    int    len;
    alpha = "oOuUwWab !x";
    repeat (5) @(negedge clk);
    check("reset_dbg", dbg, 24'h0);
    check("reset_tx", {31'b0, tx}, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_str("owo ");
    drain();
    check("owo_state", {28'b0, dbg[3:0]}, 0);
    run_str("UWU!");
    drain();
    run_str("hellowo world\n");
    drain();
    run_str("owO ");
    drain();
    check("owO_state", {28'b0, dbg[3:0]}, 0);

    // Held partial match followed by a long idle.
`ifdef DEUWU_TIMEOUT_EN
    exp_q.push_back("o");
    exp_q.push_back("w");
`endif
    send_byte("o");
    send_byte("w");
    check("hold_state", {28'b0, dbg[3:0]}, 3);
    check("hold_c1", {24'b0, dbg[23:16]}, "o");
    check("hold_last", {24'b0, dbg[15:8]}, "w");
    repeat (3 * 10 * CPB) @(negedge clk);
`ifdef DEUWU_TIMEOUT_EN
    check("timeout_state", {28'b0, dbg[3:0]}, 0);
`else
    check("idle_state", {28'b0, dbg[3:0]}, 3);
    check("idle_no_output", exp_q.size(), 0);
    exp_q.push_back("o");
    exp_q.push_back("w");
`endif
    exp_q.push_back("x");
    exp_q.push_back(" ");
    send_byte("x");
    send_byte(" ");
    drain();

    // Reset in the middle of a match.
    send_byte("u");
    send_byte("w");
    check("pre_reset_state", {28'b0, dbg[3:0]}, 3);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_reset_dbg", dbg, 24'h0);
    check("mid_reset_tx", {31'b0, tx}, 1);
    rst = 1'b0;
    run_str("a ");
    drain();

    // Random words biased towards the match characters.
    for (int seg = 0; seg < 15; seg++) begin
      stim_q.delete();
      len = $urandom_range(3, 10);
      for (int k = 0; k < len; k++) stim_q.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
      stim_q.push_back(" ");
      send_stim();
      drain();
      check("rand_state", {28'b0, dbg[3:0]}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
